snn_fc_layer_sequencer: RTL and testbench

Sequences one stochastic evaluation of an 8-node fully connected SNN layer. It drives the layer's INIT and CLK_TRAINING_flag controls, discards a settle window, then counts ones on each node's a_out bitstream over a fixed stream length to give a per-node activation estimate. It sits between the network-level controller (start/done handshake) and one fully connected layer instance; each layer gets one sequencer.

---
 rtl/snn_seq_pkg.sv | 29 ++
 rtl/snn_stream_counter.sv | 41 ++++
 rtl/snn_fc_layer_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_snn_fc_layer_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_seq_pkg.sv
// Shared types and defaults for the SNN fully connected layer sequencer.
// Contents: sequencer state enum, default phase lengths, count-width helper.
package snn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_TRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_N_NODES      = 8;
  localparam int unsigned DEF_STREAM_LEN   = 256;
  localparam int unsigned DEF_INIT_CYCLES  = 2;
  localparam int unsigned DEF_SETTLE_LEN   = 4;
  localparam int unsigned DEF_TRAIN_CYCLES = 1;

  // Bits needed to hold any value 0..len inclusive.
  function automatic int unsigned calc_cw(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/snn_stream_counter.sv
// Per-node ones counter for one stochastic bitstream.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i zeroes the count,
// en_i adds bit_i each cycle; count_next_c = current count plus this cycle's bit
// (combinational, lets the owner capture the final total on the last cycle).
module snn_stream_counter
  import snn_seq_pkg::*;
#(
  parameter int unsigned CW = calc_cw(DEF_STREAM_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          bit_i,
  output logic [CW-1:0] count_next_c
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count_next_c = count_q + CW'(bit_i);

  // Clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_next_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/snn_fc_layer_sequencer.sv
// Sequences one stochastic evaluation of a fully connected SNN layer:
// INIT pulse, settle window, RUN window counting ones per node on a_out,
// optional TRAIN pulse, then a one-cycle done with per-node counts.
// Ports: CLK, INIT_N (async active-low reset); start/train_req/abort control;
// a_out/zp layer bitstreams; layer_init/layer_train_flag layer controls;
// busy/done/count_valid status; count_out per-node counts (node i at [i*CW +: CW]).
// Optional build macro ZP_COUNT_EN adds a second bank counting zp into zp_count_out.
module snn_fc_layer_sequencer
  import snn_seq_pkg::*;
#(
  parameter int unsigned N_NODES      = DEF_N_NODES,
  parameter int unsigned STREAM_LEN   = DEF_STREAM_LEN,
  parameter int unsigned INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int unsigned SETTLE_LEN   = DEF_SETTLE_LEN,
  parameter int unsigned TRAIN_CYCLES = DEF_TRAIN_CYCLES,
  parameter int unsigned CW           = calc_cw(STREAM_LEN)
) (
  input  logic                  CLK,
  input  logic                  INIT_N,
  input  logic                  start,
  input  logic                  train_req,
  input  logic                  abort,
  input  logic [N_NODES-1:0]    a_out,
  input  logic [N_NODES-1:0]    zp,
  output logic                  layer_init,
  output logic                  layer_train_flag,
  output logic                  busy,
  output logic                  done,
  output logic                  count_valid,
  output logic [N_NODES*CW-1:0] count_out
`ifdef ZP_COUNT_EN
  ,
  output logic [N_NODES*CW-1:0] zp_count_out
`endif
);

  localparam int unsigned PHASE_MAX = max_u(max_u(INIT_CYCLES, SETTLE_LEN),
                                            max_u(STREAM_LEN, TRAIN_CYCLES));
  localparam int unsigned PW = calc_cw(PHASE_MAX);

  seq_state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic train_q, train_d;
  logic count_valid_q, count_valid_d;
  logic layer_init_q, layer_train_flag_q, busy_q, done_q;
  logic load_cnt_c;
  logic cnt_clr_c, cnt_en_c;
  logic phase_last_c;
  logic [N_NODES*CW-1:0] a_next_c;
  logic [N_NODES*CW-1:0] count_out_q;

  assign phase_last_c = (phase_q == '0);
  assign cnt_clr_c    = (state_q == ST_INIT);
  assign cnt_en_c     = (state_q == ST_RUN);

  // State register and phase down-counter.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      train_q       <= 1'b0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      train_q       <= train_d;
      count_valid_q <= count_valid_d;
    end
  end

  // Next-state logic; each phase transition loads the next phase length minus one.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    train_d       = train_q;
    count_valid_d = count_valid_q;
    load_cnt_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d       = ST_INIT;
          phase_d       = PW'(INIT_CYCLES - 1);
          train_d       = train_req;
          count_valid_d = 1'b0;
        end
      end
      ST_INIT: begin
        if (phase_last_c) begin
          if (SETTLE_LEN == 0) begin
            state_d = ST_RUN;
            phase_d = PW'(STREAM_LEN - 1);
          end else begin
            state_d = ST_SETTLE;
            phase_d = PW'(SETTLE_LEN - 1);
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_SETTLE: begin
        if (phase_last_c) begin
          state_d = ST_RUN;
          phase_d = PW'(STREAM_LEN - 1);
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_RUN: begin
        if (phase_last_c) begin
          load_cnt_c = 1'b1;
          if (train_q) begin
            state_d = ST_TRAIN;
            phase_d = PW'(TRAIN_CYCLES - 1);
          end else begin
            state_d       = ST_DONE;
            count_valid_d = 1'b1;
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_TRAIN: begin
        if (phase_last_c) begin
          state_d       = ST_DONE;
          count_valid_d = 1'b1;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every phase-end decision, including the final count load.
    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      load_cnt_c    = 1'b0;
      count_valid_d = 1'b0;
    end
  end

  // Moore outputs registered from the next state so they align with state_q.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      layer_init_q       <= 1'b0;
      layer_train_flag_q <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      layer_init_q       <= (state_d == ST_INIT);
      layer_train_flag_q <= (state_d == ST_TRAIN);
      busy_q             <= (state_d != ST_IDLE);
      done_q             <= (state_d == ST_DONE);
    end
  end

  // Per-node a_out counters.
  for (genvar i = 0; i < N_NODES; i++) begin : g_a_cnt
    snn_stream_counter #(.CW(CW)) u_cnt (
      .clk_i        (CLK),
      .rst_ni       (INIT_N),
      .clr_i        (cnt_clr_c),
      .en_i         (cnt_en_c),
      .bit_i        (a_out[i]),
      .count_next_c (a_next_c[i*CW +: CW])
    );
  end

  // Result register captures counts including the last RUN cycle's bits.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      count_out_q <= '0;
    end else if (load_cnt_c) begin
      count_out_q <= a_next_c;
    end
  end

`ifdef ZP_COUNT_EN
  logic [N_NODES*CW-1:0] zp_next_c;
  logic [N_NODES*CW-1:0] zp_count_out_q;

  // Per-node zp counters, same window as a_out.
  for (genvar i = 0; i < N_NODES; i++) begin : g_zp_cnt
    snn_stream_counter #(.CW(CW)) u_cnt (
      .clk_i        (CLK),
      .rst_ni       (INIT_N),
      .clr_i        (cnt_clr_c),
      .en_i         (cnt_en_c),
      .bit_i        (zp[i]),
      .count_next_c (zp_next_c[i*CW +: CW])
    );
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      zp_count_out_q <= '0;
    end else if (load_cnt_c) begin
      zp_count_out_q <= zp_next_c;
    end
  end

  assign zp_count_out = zp_count_out_q;
`else
  logic unused_zp;
  assign unused_zp = ^zp;
`endif

  assign layer_init       = layer_init_q;
  assign layer_train_flag = layer_train_flag_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign count_valid      = count_valid_q;
  assign count_out        = count_out_q;

endmodule

// File: tb/tb_snn_fc_layer_sequencer.sv
// Self-checking bench for snn_fc_layer_sequencer (STREAM_LEN=16, SETTLE_LEN=4,
// INIT_CYCLES=2, TRAIN_CYCLES=3). Expected timing comes from the phase lengths;
// expected counts are the ones in each node's stream over the RUN window.
module tb_snn_fc_layer_sequencer;

  localparam int unsigned NN  = 8;
  localparam int unsigned SL  = 16;
  localparam int unsigned IC  = 2;
  localparam int unsigned ST  = 4;
  localparam int unsigned TC  = 3;
  localparam int unsigned CWB = $clog2(SL + 1);

  logic CLK;
  logic INIT_N;
  logic start;
  logic train_req;
  logic abort;
  logic [NN-1:0] a_out;
  logic [NN-1:0] zp;
  logic layer_init;
  logic layer_train_flag;
  logic busy;
  logic done;
  logic count_valid;
  logic [NN*CWB-1:0] count_out;
`ifdef ZP_COUNT_EN
  logic [NN*CWB-1:0] zp_count_out;
`endif

  snn_fc_layer_sequencer #(
    .N_NODES      (NN),
    .STREAM_LEN   (SL),
    .INIT_CYCLES  (IC),
    .SETTLE_LEN   (ST),
    .TRAIN_CYCLES (TC)
  ) dut (
    .CLK              (CLK),
    .INIT_N           (INIT_N),
    .start            (start),
    .train_req        (train_req),
    .abort            (abort),
    .a_out            (a_out),
    .zp               (zp),
    .layer_init       (layer_init),
    .layer_train_flag (layer_train_flag),
    .busy             (busy),
    .done             (done),
    .count_valid      (count_valid),
    .count_out        (count_out)
`ifdef ZP_COUNT_EN
    ,
    .zp_count_out     (zp_count_out)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int prev_a [NN];
  int prev_z [NN];
  logic [NN-1:0] a_stream [0:63];
  logic [NN-1:0] z_stream [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] node_of(input logic [NN*CWB-1:0] v, input int i);
    return 32'(v[i*CWB +: CWB]);
  endfunction

  task automatic chk_counts(input string tag, input int ea [NN], input int ez [NN]);
    for (int i = 0; i < NN; i++) begin
      chk($sformatf("%s_a%0d", tag, i), node_of(count_out, i), 32'(ea[i]));
`ifdef ZP_COUNT_EN
      chk($sformatf("%s_zp%0d", tag, i), node_of(zp_count_out, i), 32'(ez[i]));
`else
      if (ez[i] < 0) $display("unexpected negative zp model value");
`endif
    end
  endtask

  // Idle cycles with start low: nothing may start and done must stay low.
  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0;
      @(negedge CLK);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_init", 32'(layer_init), 32'd0);
    end
  endtask

  // One full evaluation starting at a negedge in IDLE; returns at the negedge
  // of the first IDLE cycle after DONE. mode 0 random, 1 all ones, 2 node-3 toggle.
  task automatic run_eval(input bit trn, input int mode, input bit hold, input bit noise);
    int a_run, a_after, d;
    int ea [NN];
    int ez [NN];
    bit exp_flag;
    a_run   = 1 + int'(IC) + int'(ST);
    a_after = a_run + int'(SL);
    d       = trn ? a_after + int'(TC) : a_after;

    for (int k = 0; k <= d + 1; k++) begin
      case (mode)
        1: begin a_stream[k] = '1; z_stream[k] = 8'hAA; end
        2: begin
          if (k >= a_run && k < a_after)
            a_stream[k] = (((k - a_run) % 2) == 0) ? 8'h08 : 8'h00;
          else
            a_stream[k] = 8'hFF;
          z_stream[k] = 8'hAA;
        end
        default: begin a_stream[k] = NN'($urandom); z_stream[k] = NN'($urandom); end
      endcase
    end

    for (int i = 0; i < NN; i++) begin
      ea[i] = 0;
      ez[i] = 0;
      for (int k = a_run; k < a_after; k++) begin
        ea[i] += int'(a_stream[k][i]);
        ez[i] += int'(z_stream[k][i]);
      end
    end

    start     = 1'b1;
    train_req = trn;
    a_out     = a_stream[0];
    zp        = z_stream[0];

    for (int n = 1; n <= d + 1; n++) begin
      @(negedge CLK);
      exp_flag = trn && (n >= a_after) && (n < a_after + int'(TC));
      chk($sformatf("init@%0d", n), 32'(layer_init), 32'((n >= 1) && (n < 1 + int'(IC))));
      chk($sformatf("train_flag@%0d", n), 32'(layer_train_flag), 32'(exp_flag));
      chk($sformatf("busy@%0d", n), 32'(busy), 32'(n <= d));
      chk($sformatf("done@%0d", n), 32'(done), 32'(n == d));
      chk($sformatf("count_valid@%0d", n), 32'(count_valid), 32'(n >= d));
      if (n == a_after - 1) chk_counts("prev_hold", prev_a, prev_z);
      if (n == d) begin
        chk_counts("result", ea, ez);
        prev_a = ea;
        prev_z = ez;
      end
      if (n <= d) begin
        start     = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
        train_req = 1'($urandom);
        a_out     = a_stream[n];
        zp        = z_stream[n];
      end else begin
        start     = hold;
        train_req = 1'b0;
      end
    end
  endtask

  // Abort on the fifth RUN cycle; result must not change and no done may appear.
  task automatic run_abort();
    int a_run;
    a_run     = 1 + int'(IC) + int'(ST);
    start     = 1'b1;
    train_req = 1'b1;
    for (int n = 1; n <= a_run + 4; n++) begin
      @(negedge CLK);
      chk($sformatf("abort_busy@%0d", n), 32'(busy), 32'd1);
      if (n == 1) chk("abort_cv_cleared", 32'(count_valid), 32'd0);
      start = 1'b0;
      a_out = NN'($urandom);
      zp    = NN'($urandom);
      if (n == a_run + 4) abort = 1'b1;
    end
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_done_after", 32'(done), 32'd0);
    chk("abort_cv_after", 32'(count_valid), 32'd0);
    chk("abort_init_after", 32'(layer_init), 32'd0);
    chk_counts("abort_hold", prev_a, prev_z);
    idle_check(3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_init"}, 32'(layer_init), 32'd0);
    chk({tag, "_flag"}, 32'(layer_train_flag), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cv"}, 32'(count_valid), 32'd0);
    for (int i = 0; i < NN; i++) begin
      prev_a[i] = 0;
      prev_z[i] = 0;
    end
    chk_counts(tag, prev_a, prev_z);
  endtask

  initial begin
    INIT_N    = 1'b1;
    start     = 1'b0;
    train_req = 1'b0;
    abort     = 1'b0;
    a_out     = '0;
    zp        = '0;
    for (int i = 0; i < NN; i++) begin
      prev_a[i] = 0;
      prev_z[i] = 0;
    end

    // Power-on reset.
    #1 INIT_N = 1'b0;
    #2 chk_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    INIT_N = 1'b1;
    idle_check(2);

    // All-ones stream: every node counts STREAM_LEN, done 23 cycles after start.
    run_eval(1'b0, 1, 1'b0, 1'b0);
    idle_check(2);

    // Node 3 toggles in RUN; ones outside RUN ignored.
    run_eval(1'b0, 2, 1'b0, 1'b0);

    // Training run then non-training run, random streams, start noise while busy.
    run_eval(1'b1, 0, 1'b0, 1'b1);
    run_eval(1'b0, 0, 1'b0, 1'b1);
    idle_check(1);

    // start together with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    chk("idle_abort_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    idle_check(1);

    run_abort();

    // start held high: each evaluation begins right after the IDLE cycle.
    run_eval(1'b1, 0, 1'b1, 1'b0);
    run_eval(1'b0, 0, 1'b1, 1'b0);
    run_eval(1'b0, 1, 1'b0, 1'b0);
    idle_check(3);

    // Random evaluations.
    for (int r = 0; r < 6; r++) begin
      run_eval(1'($urandom), 0, 1'b0, 1'b1);
      idle_check(int'($urandom_range(0, 2)));
    end

    // Asynchronous reset mid-RUN.
    start = 1'b1;
    train_req = 1'b0;
    for (int n = 1; n <= 1 + int'(IC) + int'(ST) + 3; n++) begin
      @(negedge CLK);
      start = 1'b0;
      a_out = NN'($urandom);
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    INIT_N = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge CLK);
    INIT_N = 1'b1;
    idle_check(2);

    run_eval(1'b0, 0, 1'b0, 1'b0);
    idle_check(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
